// File: rtl/phase_marker_pkg.sv
// Shared definitions for the commit-stream phase-marker protocol (emitter and monitor).
package phase_marker_pkg;

    localparam int unsigned INST_W    = 32;
    localparam int unsigned PHASE_W   = 3;
    localparam int unsigned IMM_W     = 12;
    localparam int unsigned DEF_LEN_W = 16;

    // Phase codes carried in a command; 7 is never a legal phase.
    typedef enum logic [PHASE_W-1:0] {
        PH_VCTM    = 3'd0,
        PH_DELAY   = 3'd1,
        PH_TEXE    = 3'd2,
        PH_LEAK    = 3'd3,
        PH_INIT    = 3'd4,
        PH_BIM     = 3'd5,
        PH_TRAIN   = 3'd6,
        PH_INVALID = 3'd7
    } phase_e;

    // Emitter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BODY  = 2'd2,
        ST_END   = 2'd3
    } emit_state_e;

    // slti x0,x0,0 : the marker encoding with a zero immediate.
    localparam logic [INST_W-1:0] MARKER_OPC_BASE = 32'h00002013;
    // addi x0,x0,0 : substituted for payload words that collide with a marker.
    localparam logic [INST_W-1:0] DEF_NOP_INST    = 32'h00000013;

    // Marker word for a phase; the immediate is {phase, is_end}.
    function automatic logic [INST_W-1:0] marker_word(input logic [PHASE_W-1:0] phase,
                                                      input logic               is_end);
        logic [IMM_W-1:0] imm;
        imm = {8'd0, phase, is_end};
        return MARKER_OPC_BASE | {imm, 20'd0};
    endfunction

    // True when a word equals any of the 14 legal marker encodings.
    function automatic logic is_marker(input logic [INST_W-1:0] word);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < 7; p++) begin
            for (int e = 0; e < 2; e++) begin
                if (word == marker_word(PHASE_W'(p), 1'(e))) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/marker_out_stage.sv
// One-entry registered output stage with a downstream valid/ready handshake.
module marker_out_stage
    import phase_marker_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [INST_W-1:0] push_inst,
    input  logic              push_marker,
    input  logic              out_ready,
    output logic              can_push_c,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic              out_is_marker
);

    // The slot may be refilled when empty or when its word leaves this cycle.
    assign can_push_c = !out_valid || out_ready;

    // Load on push, drain on pop, otherwise hold the entry stable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            out_inst      <= '0;
            out_is_marker <= 1'b0;
        end else if (push && can_push_c) begin
            out_valid     <= 1'b1;
            out_inst      <= push_inst;
            out_is_marker <= push_marker;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/phase_marker_emitter.sv
// Brackets a payload instruction stream with START/END phase markers.
module phase_marker_emitter
    import phase_marker_pkg::*;
#(
    parameter int unsigned       LEN_W    = DEF_LEN_W,
    parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [PHASE_W-1:0] cmd_phase,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               pay_valid,
    output logic               pay_ready,
    input  logic [INST_W-1:0]  pay_inst,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INST_W-1:0]  out_inst,
    output logic               out_is_marker,
    output logic               busy,
    output logic [PHASE_W-1:0] cur_phase,
    output logic               err_bad_phase,
    output logic               err_marker_in_payload
);

    emit_state_e        state, state_nxt;
    logic [LEN_W-1:0]   remaining, remaining_nxt;
    logic [PHASE_W-1:0] phase_nxt;
    logic               err_bad_phase_nxt;
    logic               err_marker_nxt;
    logic               push;
    logic [INST_W-1:0]  push_inst;
    logic               push_marker;
    logic               can_push;

    marker_out_stage u_out_stage (
        .clock         (clock),
        .reset         (reset),
        .push          (push),
        .push_inst     (push_inst),
        .push_marker   (push_marker),
        .out_ready     (out_ready),
        .can_push_c    (can_push),
        .out_valid     (out_valid),
        .out_inst      (out_inst),
        .out_is_marker (out_is_marker)
    );

    assign busy = (state != ST_IDLE) || out_valid;

    // State, length counter, active phase and sticky error flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state                 <= ST_IDLE;
            remaining             <= '0;
            cur_phase             <= '0;
            err_bad_phase         <= 1'b0;
            err_marker_in_payload <= 1'b0;
        end else begin
            state                 <= state_nxt;
            remaining             <= remaining_nxt;
            cur_phase             <= phase_nxt;
            err_bad_phase         <= err_bad_phase_nxt;
            err_marker_in_payload <= err_marker_nxt;
        end
    end

    // Next-state, handshake and output-stage load decisions.
    always_comb begin
        state_nxt         = state;
        remaining_nxt     = remaining;
        phase_nxt         = cur_phase;
        err_bad_phase_nxt = err_bad_phase;
        err_marker_nxt    = err_marker_in_payload;
        push              = 1'b0;
        push_inst         = '0;
        push_marker       = 1'b0;
        cmd_ready         = 1'b0;
        pay_ready         = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_phase == PH_INVALID) begin
                        // Swallow the command; nothing is emitted for it.
                        err_bad_phase_nxt = 1'b1;
                    end else begin
                        phase_nxt     = cmd_phase;
                        remaining_nxt = cmd_len;
                        state_nxt     = ST_START;
                    end
                end
            end

            ST_START: begin
                if (can_push) begin
                    push        = 1'b1;
                    push_inst   = marker_word(cur_phase, 1'b0);
                    push_marker = 1'b1;
                    state_nxt   = (remaining == '0) ? ST_END : ST_BODY;
                end
            end

            ST_BODY: begin
                pay_ready = can_push;
                if (pay_valid && can_push) begin
                    push = 1'b1;
                    // A payload word must never be mistaken for a marker downstream.
                    if (is_marker(pay_inst)) begin
                        push_inst      = NOP_INST;
                        err_marker_nxt = 1'b1;
                    end else begin
                        push_inst      = pay_inst;
                    end
                    if (remaining != '0) begin
                        remaining_nxt = remaining - LEN_W'(1);
                    end
                    if (remaining <= LEN_W'(1)) begin
                        state_nxt = ST_END;
                    end
                end
            end

            ST_END: begin
                if (can_push) begin
                    push        = 1'b1;
                    push_inst   = marker_word(cur_phase, 1'b1);
                    push_marker = 1'b1;
                    phase_nxt   = '0;
                    state_nxt   = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_phase_marker_emitter.sv
// Directed self-checking bench for phase_marker_emitter.
module tb_phase_marker_emitter;

    localparam int unsigned LEN_W = 16;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_phase;
    logic [15:0] cmd_len;
    logic        pay_valid;
    logic        pay_ready;
    logic [31:0] pay_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_is_marker;
    logic        busy;
    logic [2:0]  cur_phase;
    logic        err_bad_phase;
    logic        err_marker_in_payload;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] beats[$];
    bit          mon_stall = 0;
    logic [32:0] mon_prev  = '0;
    bit          pay_seen  = 0;
    bit          rand_bp   = 0;

    phase_marker_emitter #(.LEN_W(LEN_W), .NOP_INST(NOP)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_phase             (cmd_phase),
        .cmd_len               (cmd_len),
        .pay_valid             (pay_valid),
        .pay_ready             (pay_ready),
        .pay_inst              (pay_inst),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_inst              (out_inst),
        .out_is_marker         (out_is_marker),
        .busy                  (busy),
        .cur_phase             (cur_phase),
        .err_bad_phase         (err_bad_phase),
        .err_marker_in_payload (err_marker_in_payload)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: record every accepted beat and verify stalled entries hold.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                mon_stall = 0;
            end else begin
                if (mon_stall) begin
                    check("stall_hold", 64'({out_valid, out_is_marker, out_inst}),
                          64'({1'b1, mon_prev}));
                end
                if (pay_ready) pay_seen = 1;
                if (out_valid && out_ready) beats.push_back({out_is_marker, out_inst});
                mon_stall = out_valid && !out_ready;
                mon_prev  = {out_is_marker, out_inst};
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] ph, input logic [15:0] len);
        bit ok;
        ok = 0;
        cmd_valid = 1'b1;
        cmd_phase = ph;
        cmd_len   = len;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        check("cmd_accept", 64'(ok), 64'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic send_pay(input logic [31:0] word);
        bit ok;
        ok = 0;
        pay_valid = 1'b1;
        pay_inst  = word;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (pay_ready) begin
                ok = 1;
                break;
            end
        end
        check("pay_accept", 64'(ok), 64'd1);
        step();
        pay_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
        step();
    endtask

    task automatic expect_stream(input string tag, input logic [32:0] exp[$]);
        check({tag, "_count"}, 64'(beats.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < beats.size()) check($sformatf("%s_beat%0d", tag, i), 64'(beats[i]), 64'(exp[i]));
        end
        beats.delete();
    endtask

    initial begin
        logic [32:0] exp[$];

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_phase = '0;
        cmd_len   = '0;
        pay_valid = 1'b0;
        pay_inst  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cur_phase", 64'(cur_phase), 64'd0);
        check("rst_errs", 64'({err_bad_phase, err_marker_in_payload}), 64'd0);
        check("rst_pay_ready", 64'(pay_ready), 64'd0);
        step();
        reset = 1'b1;
        step();

        // TEXE, three payload words, with start-marker latency probe.
        send_cmd(3'd2, 16'd3);
        @(negedge clock);
        check("t1_lat_start_cycle", 64'(out_valid), 64'd0);
        check("t1_cur_phase", 64'(cur_phase), 64'd2);
        check("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
        @(negedge clock);
        check("t1_lat_marker", 64'({out_valid, out_is_marker, out_inst}),
              64'({2'b11, 32'h00402013}));
        step();
        send_pay(32'hA000_0001);
        send_pay(32'hB000_0002);
        send_pay(32'hC000_0003);
        wait_idle("t1_idle");
        check("t1_cur_phase_idle", 64'(cur_phase), 64'd0);
        exp = '{{1'b1, 32'h00402013}, {1'b0, 32'hA000_0001}, {1'b0, 32'hB000_0002},
                {1'b0, 32'hC000_0003}, {1'b1, 32'h00502013}};
        expect_stream("t1", exp);

        // TRAIN with zero length; a pending payload word must not be taken.
        pay_seen  = 0;
        pay_valid = 1'b1;
        pay_inst  = 32'h1234_5678;
        send_cmd(3'd6, 16'd0);
        wait_idle("t2_idle");
        repeat (2) step();
        check("t2_pay_ready_never", 64'(pay_seen), 64'd0);
        pay_valid = 1'b0;
        exp = '{{1'b1, 32'h00c02013}, {1'b1, 32'h00d02013}};
        expect_stream("t2", exp);

        // Invalid phase is swallowed, then a valid VCTM command follows.
        send_cmd(3'd7, 16'd5);
        @(negedge clock);
        check("t3_err_bad_phase", 64'(err_bad_phase), 64'd1);
        check("t3_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clock);
        check("t3_no_beats", 64'(beats.size()), 64'd0);
        step();
        send_cmd(3'd0, 16'd1);
        send_pay(32'hE000_0005);
        wait_idle("t3_idle");
        exp = '{{1'b1, 32'h00002013}, {1'b0, 32'hE000_0005}, {1'b1, 32'h00102013}};
        expect_stream("t3", exp);

        // A marker-looking payload word is replaced with NOP.
        check("t4_err_mk_before", 64'(err_marker_in_payload), 64'd0);
        send_cmd(3'd4, 16'd2);
        send_pay(32'h00602013);
        send_pay(32'hD000_0004);
        wait_idle("t4_idle");
        check("t4_err_mk", 64'(err_marker_in_payload), 64'd1);
        exp = '{{1'b1, 32'h00802013}, {1'b0, NOP}, {1'b0, 32'hD000_0004},
                {1'b1, 32'h00902013}};
        expect_stream("t4", exp);

        // DELAY under random downstream backpressure.
        rand_bp = 1;
        send_cmd(3'd1, 16'd4);
        send_pay(32'hF000_0010);
        send_pay(32'hF000_0011);
        send_pay(32'hF000_0012);
        send_pay(32'hF000_0013);
        for (int i = 0; i < 200 && busy; i++) step();
        rand_bp   = 0;
        out_ready = 1'b1;
        wait_idle("t5_idle");
        check("t5_err_mk_sticky", 64'(err_marker_in_payload), 64'd1);
        check("t5_err_bp_sticky", 64'(err_bad_phase), 64'd1);
        exp = '{{1'b1, 32'h00202013}, {1'b0, 32'hF000_0010}, {1'b0, 32'hF000_0011},
                {1'b0, 32'hF000_0012}, {1'b0, 32'hF000_0013}, {1'b1, 32'h00302013}};
        expect_stream("t5", exp);

        // Reset in the middle of a LEAK body: no END marker afterwards.
        send_cmd(3'd3, 16'd4);
        send_pay(32'h5500_0000);
        send_pay(32'h5500_0001);
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clock);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_out_inst", 64'(out_inst), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_cur_phase", 64'(cur_phase), 64'd0);
        check("t6_errs", 64'({err_bad_phase, err_marker_in_payload}), 64'd0);
        repeat (5) @(negedge clock);
        step();
        exp = '{{1'b1, 32'h00602013}, {1'b0, 32'h5500_0000}};
        expect_stream("t6", exp);
        send_cmd(3'd5, 16'd1);
        send_pay(32'h6600_0007);
        wait_idle("t6_idle");
        exp = '{{1'b1, 32'h00a02013}, {1'b0, 32'h6600_0007}, {1'b1, 32'h00b02013}};
        expect_stream("t6_after", exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_marker_emitter.md
Name: phase_marker_emitter

Overview:
- Transmit side of the commit-stream phase-marker protocol.
- Takes phase commands plus a payload instruction stream and emits one merged instruction stream: a START marker, N payload words, then an END marker.
- Sits in the stimulus/instruction feeder ahead of the DUT fetch path. It produces exactly the marker encodings that the commit-side monitor decodes into VCTM/DELAY/TEXE/LEAK/INIT/BIM/TRAIN events.

Parameters:
- LEN_W, 16, width of the payload length field in a command.
- NOP_INST, 32'h00000013, word substituted for an illegal payload word.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-low
- cmd_valid  in  1  phase command valid
- cmd_ready  out  1  phase command accepted when valid && ready
- cmd_phase  in  3  0=VCTM 1=DELAY 2=TEXE 3=LEAK 4=INIT 5=BIM 6=TRAIN, 7=invalid
- cmd_len  in  LEN_W  number of payload words to bracket
- pay_valid  in  1  payload word valid
- pay_ready  out  1  payload word accepted
- pay_inst  in  32  payload instruction word
- out_valid  out  1  merged stream valid
- out_ready  in  1  downstream accepts
- out_inst  out  32  merged stream word
- out_is_marker  out  1  out_inst is a marker generated by this block
- busy  out  1  state != IDLE or out_valid
- cur_phase  out  3  phase of the active command, 0 when idle
- err_bad_phase  out  1  sticky: a command with phase 7 was accepted
- err_marker_in_payload  out  1  sticky: a payload word matched a marker encoding

Behaviour:
- Marker encoding: instruction slti x0,x0,imm, i.e. {imm[11:0], 5'd0, 3'b010, 5'd0, 7'h13}.
  - imm = {phase, is_end}, giving 32'h00002013 (VCTM_START) through 32'h00d02013 (TRAIN_END).
  - This encoding belongs in the shared package only; it is not duplicated in RTL.
- Output stage: single registered entry (out_valid, out_inst, out_is_marker).
  - can_push = !out_valid || out_ready.
  - The entry holds stable while out_valid && !out_ready.
- FSM states: IDLE, START, BODY, END.
  - IDLE: cmd_ready=1.
    - cmd_phase=7: the command is consumed, err_bad_phase is set, state stays IDLE, nothing is emitted.
    - Otherwise: latch phase into cur_phase, latch cmd_len into remaining counter, go to START.
  - START: when can_push, load the start marker (out_is_marker=1).
    - remaining==0: go to END.
    - Otherwise: go to BODY.
  - BODY: pay_ready = can_push.
    - On a payload handshake, load pay_inst (out_is_marker=0) and decrement remaining.
    - Going from 1 to 0 moves the state to END.
    - A word equal to any of the 14 marker encodings is replaced by NOP_INST and sets err_marker_in_payload.
  - END: when can_push, load the end marker and go to IDLE. cur_phase clears to 0 on leaving END.
- Ready outputs:
  - cmd_ready is 1 only in IDLE.
  - pay_ready is 0 outside BODY.
  - Neither depends combinationally on its own valid.
- Latency and throughput:
  - The start marker is visible at out_valid 2 cycles after the command handshake (1 cycle in START).
  - In BODY, throughput is 1 word per cycle with out_ready held high.
  - A full command with len=N occupies N+2 output beats minimum.
  - The next command is accepted in the cycle after END pushes (IDLE).
- Counter: remaining is LEN_W bits and never wraps. A decrement happens only when nonzero.
- Reset (reset==0 at a clock edge), including mid-operation:
  - State goes to IDLE; out_valid, out_is_marker, cur_phase, remaining, and both error flags go to 0.
  - out_inst goes to 0.
  - No partial END marker is emitted after reset.
- Simultaneous events:
  - A downstream pop and a new push in the same cycle is legal (can_push via out_ready).
  - A payload valid outside BODY is ignored and stays pending.

Decomposition:
- Package phase_marker_pkg holds:
  - the phase_e enum (VCTM..TRAIN, INVALID=7);
  - localparam MARKER_OPC_BASE = 32'h00002013;
  - function marker_word(phase, is_end);
  - function is_marker(word).
- The package is shared with the commit-side monitor.
- One sub-module, marker_out_stage: the one-entry output register with can_push.

Test Plan:
- cmd(phase=2, len=3), payload A,B,C, out_ready=1 -> out stream 32'h00402013, A, B, C, 32'h00502013; is_marker = 1,0,0,0,1; busy low after the last beat.
- cmd(phase=6, len=0) -> exactly 32'h00c02013 then 32'h00d02013; pay_ready never asserted.
- cmd(phase=7, len=5) -> err_bad_phase=1, no output beats, cmd_ready=1 next cycle; the next valid cmd(phase=0, len=1) emits 32'h00002013, payload, 32'h00102013.
- cmd(phase=4, len=2) with payload 32'h00602013, D -> emitted body is NOP_INST 32'h00000013, D; err_marker_in_payload=1 and sticky through the next command.
- Backpressure: out_ready toggled randomly during cmd(phase=1, len=4) -> out_inst/out_is_marker stable while stalled, no beat lost or duplicated, order 00202013, P0..P3, 00302013.
- Reset asserted in BODY after 2 of 4 payload words -> next cycle out_valid=0, busy=0, cur_phase=0, flags=0; no END marker emitted; a new command proceeds normally.
